// File: rtl/dmem_pkg.sv
// dmem_pkg: shared definitions for the data-memory responder.
//   - MMIO_BASE_DEFAULT : default base address of the MMIO window
//   - OFF_*             : byte offsets of the MMIO registers inside the window
//   - STATUS_*          : bit positions of the STATUS register fields
//   - region_e          : address-decode result
package dmem_pkg;

    localparam logic [31:0] MMIO_BASE_DEFAULT = 32'hFFFF_0000;

    localparam logic [15:0] OFF_TXDATA = 16'h0000;
    localparam logic [15:0] OFF_STATUS = 16'h0004;
    localparam logic [15:0] OFF_CYCLE  = 16'h0008;

    localparam int STATUS_EMPTY_BIT = 0;
    localparam int STATUS_FULL_BIT  = 1;
    localparam int STATUS_OVF_BIT   = 2;
    localparam int STATUS_COUNT_LSB = 8;

    typedef enum logic [1:0] {
        REGION_RAM,
        REGION_MMIO,
        REGION_UNMAPPED
    } region_e;

endpackage

// File: rtl/dmem_responder_tx_fifo.sv
// tx_fifo: synchronous FIFO with registered pointers and occupancy count.
// Ports:
//   clk, reset_n         : clock, asynchronous active-low reset
//   push, push_data      : enqueue request and data (ignored when full unless popping)
//   pop                  : dequeue request (ignored when empty)
//   head                 : oldest entry, forced to 0 when empty
//   full, empty, count   : occupancy status, count in 0..DEPTH
module tx_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 8
) (
    input  logic                     clk,
    input  logic                     reset_n,
    input  logic                     push,
    input  logic [WIDTH-1:0]         push_data,
    input  logic                     pop,
    output logic [WIDTH-1:0]         head,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int PW = $clog2(DEPTH);
    localparam logic [PW:0] FULL_COUNT = (PW+1)'(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [PW:0]      count_q, count_d;
    logic             do_push, do_pop;

    always_comb begin
        empty   = (count_q == '0);
        full    = (count_q == FULL_COUNT);
        do_pop  = pop && !empty;
        // A pop in the same cycle frees the slot, so a full FIFO still accepts.
        do_push = push && (!full || do_pop);

        wr_ptr_d = do_push ? wr_ptr_q + PW'(1) : wr_ptr_q;
        rd_ptr_d = do_pop  ? rd_ptr_q + PW'(1) : rd_ptr_q;

        count_d = count_q;
        if (do_push && !do_pop) begin
            count_d = count_q + (PW+1)'(1);
        end else if (do_pop && !do_push) begin
            count_d = count_q - (PW+1)'(1);
        end

        head  = empty ? '0 : mem[rd_ptr_q];
        count = count_q;
    end

    // NOTE: storage is deliberately not reset; the pointers alone define which
    // entries are valid, and leaving the array reset-free lets it map to RAM.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr_q] <= push_data;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

endmodule

// File: rtl/dmem_responder.sv
// dmem_responder: data-port responder for the single-cycle CPU.
// Word RAM with byte-lane writes plus an MMIO window holding a console
// transmit FIFO (TXDATA), a STATUS register and a free-running CYCLE counter.
// Ports:
//   clk, reset_n           : clock, asynchronous active-low reset
//   daddr, dwdata, dwe     : CPU byte address, lane-aligned write data, lane enables
//   drdata                 : combinational read data
//   tx_data, tx_valid      : FIFO head and non-empty flag
//   tx_ready               : consumer takes tx_data this cycle
//   bus_err                : sticky unmapped-access flag
module dmem_responder
    import dmem_pkg::*;
#(
    parameter int          DEPTH_WORDS = 1024,
    parameter int          FIFO_DEPTH  = 8,
    parameter logic [31:0] MMIO_BASE   = MMIO_BASE_DEFAULT
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic [31:0] daddr,
    input  logic [31:0] dwdata,
    input  logic [3:0]  dwe,
    output logic [31:0] drdata,
    output logic [7:0]  tx_data,
    output logic        tx_valid,
    input  logic        tx_ready,
    output logic        bus_err
);

    localparam int AW = $clog2(DEPTH_WORDS);
    localparam int CW = $clog2(FIFO_DEPTH) + 1;

    logic [31:0]   mem [DEPTH_WORDS];
    region_e       region;
    logic [AW-1:0] word_idx;
    logic [15:0]   mmio_off;
    logic          fifo_push, fifo_pop, fifo_full, fifo_empty;
    logic [CW-1:0] fifo_count;
    logic [7:0]    fifo_head;
    logic          ovf_set, ovf_clr;
    logic [31:0]   status_word;
    logic [31:0]   cycle_q, cycle_d;
    logic          ovf_q, ovf_d;
    logic          bus_err_q, bus_err_d;
    logic          unused_addr_lsbs;

    // Lane selection and extension happen in the CPU; the low address bits
    // carry no meaning here.
    assign unused_addr_lsbs = ^daddr[1:0];
    assign word_idx         = daddr[AW+1:2];
    assign mmio_off         = {daddr[15:2], 2'b00};

    // MMIO takes priority; RAM is the low DEPTH_WORDS words.
    always_comb begin
        // NOTE: every combinational output gets a default first, so no path
        // can leave it unassigned and infer a latch.
        region = REGION_UNMAPPED;
        if (daddr[31:16] == MMIO_BASE[31:16]) begin
            region = REGION_MMIO;
        end else if (daddr[31:AW+2] == '0) begin
            region = REGION_RAM;
        end
    end

    always_comb begin
        fifo_pop  = !fifo_empty && tx_ready;
        fifo_push = (region == REGION_MMIO) && (mmio_off == OFF_TXDATA) && dwe[0];
        ovf_clr   = (region == REGION_MMIO) && (mmio_off == OFF_STATUS) && dwe[0]
                    && dwdata[STATUS_OVF_BIT];
        // A same-cycle pop makes room, so only a push into a static full FIFO drops.
        ovf_set   = fifo_push && fifo_full && !fifo_pop;

        status_word                              = '0;
        status_word[STATUS_EMPTY_BIT]            = fifo_empty;
        status_word[STATUS_FULL_BIT]             = fifo_full;
        status_word[STATUS_OVF_BIT]              = ovf_q;
        status_word[STATUS_COUNT_LSB +: CW]      = fifo_count;

        drdata = '0;
        case (region)
            REGION_RAM:  drdata = mem[word_idx];
            REGION_MMIO: begin
                case (mmio_off)
                    OFF_STATUS: drdata = status_word;
                    OFF_CYCLE:  drdata = cycle_q;
                    default:    drdata = '0;
                endcase
            end
            default:     drdata = '0;
        endcase

        cycle_d   = cycle_q + 32'd1;
        // Set has priority over clear when both land on the same edge.
        ovf_d     = ovf_set || (ovf_q && !ovf_clr);
        bus_err_d = bus_err_q || (region == REGION_UNMAPPED);
    end

    tx_fifo #(
        .WIDTH (8),
        .DEPTH (FIFO_DEPTH)
    ) u_tx_fifo (
        .clk       (clk),
        .reset_n   (reset_n),
        .push      (fifo_push),
        .push_data (dwdata[7:0]),
        .pop       (fifo_pop),
        .head      (fifo_head),
        .full      (fifo_full),
        .empty     (fifo_empty),
        .count     (fifo_count)
    );

    assign tx_valid = !fifo_empty;
    assign tx_data  = fifo_head;
    assign bus_err  = bus_err_q;

    // The RAM has no reset path, so writes are explicitly blocked while
    // reset_n is low; reads stay live.
    always_ff @(posedge clk) begin
        if (reset_n && (region == REGION_RAM)) begin
            for (int i = 0; i < 4; i++) begin
                if (dwe[i]) begin
                    mem[word_idx][8*i +: 8] <= dwdata[8*i +: 8];
                end
            end
        end
    end

    // NOTE: state registers use non-blocking assignments so every flop samples
    // the pre-edge values regardless of statement order.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cycle_q   <= '0;
            ovf_q     <= 1'b0;
            bus_err_q <= 1'b0;
        end else begin
            cycle_q   <= cycle_d;
            ovf_q     <= ovf_d;
            bus_err_q <= bus_err_d;
        end
    end

endmodule

// File: tb/tb_dmem_responder.sv
// tb_dmem_responder: self-checking bench for dmem_responder.
// A behavioural model (word array, byte queue, two flags) is advanced once
// per clock edge from the inputs applied in that cycle; DUT outputs are
// sampled 1-3 ns after the rising edge and compared against the model.
module tb_dmem_responder;

    localparam int          FIFO_DEPTH = 8;
    localparam logic [31:0] A_TXDATA   = 32'hFFFF_0000;
    localparam logic [31:0] A_STATUS   = 32'hFFFF_0004;
    localparam logic [31:0] A_CYCLE    = 32'hFFFF_0008;

    logic        clk;
    logic        reset_n;
    logic [31:0] daddr;
    logic [31:0] dwdata;
    logic [3:0]  dwe;
    logic [31:0] drdata;
    logic [7:0]  tx_data;
    logic        tx_valid;
    logic        tx_ready;
    logic        bus_err;

    // Behavioural model state.
    logic [31:0] mem_m [1024];
    byte unsigned txq [$];
    bit          ovf_m;
    bit          bus_err_m;

    int n_checks;
    int n_errors;

    dmem_responder dut (
        .clk      (clk),
        .reset_n  (reset_n),
        .daddr    (daddr),
        .dwdata   (dwdata),
        .dwe      (dwe),
        .drdata   (drdata),
        .tx_data  (tx_data),
        .tx_valid (tx_valid),
        .tx_ready (tx_ready),
        .bus_err  (bus_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic bit is_mmio_addr(input logic [31:0] a);
        return a[31:16] == 16'hFFFF;
    endfunction

    function automatic bit is_ram_addr(input logic [31:0] a);
        return !is_mmio_addr(a) && (a < 32'h0000_1000);
    endfunction

    function automatic logic [31:0] model_status();
        logic [31:0] s;
        s       = '0;
        s[0]    = (txq.size() == 0);
        s[1]    = (txq.size() == FIFO_DEPTH);
        s[2]    = ovf_m;
        s[15:8] = 8'(txq.size());
        return s;
    endfunction

    // Applies the rules for one rising edge to the model using current inputs.
    function automatic void model_edge();
        bit          mmio = is_mmio_addr(daddr);
        bit          ram  = is_ram_addr(daddr);
        logic [15:0] off  = {daddr[15:2], 2'b00};
        bit          full = (txq.size() == FIFO_DEPTH);
        bit          pop  = (txq.size() != 0) && tx_ready;
        bit          push = mmio && (off == 16'h0000) && dwe[0];
        bit          clr  = mmio && (off == 16'h0004) && dwe[0] && dwdata[2];
        logic [31:0] w;
        if (clr) ovf_m = 1'b0;
        if (push && full && !pop) ovf_m = 1'b1;
        if (pop) void'(txq.pop_front());
        if (push && (!full || pop)) txq.push_back(dwdata[7:0]);
        if (ram && dwe != 4'b0) begin
            w = mem_m[daddr[11:2]];
            for (int i = 0; i < 4; i++) begin
                if (dwe[i]) w[8*i +: 8] = dwdata[8*i +: 8];
            end
            mem_m[daddr[11:2]] = w;
        end
        if (!mmio && !ram) bus_err_m = 1'b1;
    endfunction

    task automatic tick();
        if (reset_n) model_edge();
        @(posedge clk);
        #1;
    endtask

    task automatic expect_read(input string tag);
        logic [31:0] exp;
        bit          skip;
        skip = 1'b0;
        exp  = '0;
        if (is_mmio_addr(daddr)) begin
            case ({daddr[15:2], 2'b00})
                16'h0004: exp = model_status();
                16'h0008: skip = 1'b1;
                default:  exp = '0;
            endcase
        end else if (is_ram_addr(daddr)) begin
            exp = mem_m[daddr[11:2]];
        end
        if (!skip) check(tag, drdata, exp);
    endtask

    task automatic check_fifo(input string tag);
        check({tag, "_tx_valid"}, {31'b0, tx_valid}, {31'b0, txq.size() != 0});
        check({tag, "_tx_data"}, {24'b0, tx_data}, {24'b0, (txq.size() != 0) ? txq[0] : 8'h00});
        check({tag, "_bus_err"}, {31'b0, bus_err}, {31'b0, bus_err_m});
    endtask

    task automatic push_byte(input byte unsigned b);
        daddr  = A_TXDATA;
        dwe    = 4'b0001;
        dwdata = {24'h0, b};
        tick();
        dwe    = 4'b0000;
    endtask

    initial begin
        logic [31:0] c0, c1;
        byte unsigned drain_exp [8];
        n_checks = 0;
        n_errors = 0;
        reset_n  = 1'b0;
        daddr    = '0;
        dwdata   = '0;
        dwe      = '0;
        tx_ready = 1'b0;
        ovf_m     = 1'b0;
        bus_err_m = 1'b0;
        repeat (3) @(posedge clk);
        #3 reset_n = 1'b1;
        @(posedge clk);
        #1;

        // Reset state.
        daddr = A_STATUS;
        #1 check("reset_status", drdata, 32'h0000_0001);
        check_fifo("reset");

        // Initialise RAM words 0..63.
        for (int i = 0; i < 64; i++) begin
            daddr  = 32'(i * 4);
            dwe    = 4'hF;
            dwdata = $urandom;
            tick();
        end
        dwe = 4'h0;

        // Byte-lane write; same-cycle read sees old data.
        daddr = 32'h10; dwe = 4'hF; dwdata = 32'h1122_3344;
        tick();
        dwe = 4'b0101; dwdata = 32'hAABB_CCDD;
        #1 check("ram_read_during_write", drdata, 32'h1122_3344);
        tick();
        dwe = 4'h0;
        #1 check("ram_lane_merge", drdata, 32'h11BB_33DD);
        expect_read("ram_lane_model");

        // Fill the FIFO with no consumer.
        tx_ready = 1'b0;
        for (int b = 8'h41; b <= 8'h48; b++) push_byte(8'(b));
        daddr = A_STATUS;
        #1 check("status_full", drdata, 32'h0000_0802);
        push_byte(8'h49);
        daddr = A_STATUS;
        #1 check("status_overflow", drdata, 32'h0000_0806);
        check("head_after_overflow", {24'b0, tx_data}, 32'h41);
        dwe = 4'b0001; dwdata = 32'h4;
        tick();
        dwe = 4'b0000;
        #1 check("status_ovf_cleared", drdata, 32'h0000_0802);

        // Push into a full FIFO while popping.
        daddr = A_TXDATA; dwe = 4'b0001; dwdata = 32'h5A; tx_ready = 1'b1;
        #1 check("head_before_push_pop", {24'b0, tx_data}, 32'h41);
        tick();
        tx_ready = 1'b0; dwe = 4'b0000; daddr = A_STATUS;
        #1 check("status_push_pop_full", drdata, 32'h0000_0802);
        check_fifo("push_pop_full");

        // Drain: one byte per cycle, 0x5A last.
        drain_exp = '{8'h42, 8'h43, 8'h44, 8'h45, 8'h46, 8'h47, 8'h48, 8'h5A};
        tx_ready = 1'b1;
        for (int i = 0; i < 8; i++) begin
            #1 check($sformatf("drain_%0d", i), {24'b0, tx_data}, {24'b0, drain_exp[i]});
            check("drain_valid", {31'b0, tx_valid}, 32'h1);
            tick();
        end
        tx_ready = 1'b0;
        #1 check("drained_status", drdata, 32'h0000_0001);
        check_fifo("drained");

        // CYCLE delta, with an ignored write in the window.
        daddr = A_CYCLE;
        #1 c0 = drdata;
        tick();
        dwe = 4'hF; dwdata = 32'h0;
        tick();
        dwe = 4'h0;
        repeat (5) tick();
        c1 = drdata;
        check("cycle_delta", c1 - c0, 32'd7);

        // CYCLE delta across the wrap point.
        force dut.cycle_q = 32'hFFFF_FFFC;
        #1 release dut.cycle_q;
        #1 c0 = drdata;
        repeat (9) tick();
        c1 = drdata;
        check("cycle_wrap_delta", c1 - c0, 32'd9);

        // Randomised traffic over RAM words 8..63 and the MMIO window.
        for (int n = 0; n < 600; n++) begin
            int unsigned r;
            r = $urandom_range(0, 9);
            case (r)
                0, 1, 2, 3, 4: daddr = {20'h0, 6'($urandom_range(8, 63)), 4'h0} >> 2
                                        | {30'h0, 2'($urandom)} | 32'((r & 1) << 7);
                5:             daddr = A_TXDATA | 32'($urandom_range(0, 3));
                6:             daddr = A_STATUS;
                7:             daddr = A_CYCLE;
                default:       daddr = 32'hFFFF_0000 | {16'h0, 14'($urandom_range(3, 16383)), 2'b00};
            endcase
            dwe      = ($urandom_range(0, 1) == 0) ? 4'h0 : 4'($urandom);
            dwdata   = $urandom;
            tx_ready = 1'($urandom);
            #1 expect_read("rnd_read");
            check_fifo("rnd");
            tick();
        end
        dwe = 4'h0;
        tx_ready = 1'b0;

        // Unmapped write.
        daddr = 32'h0; #1 c0 = drdata;
        daddr = 32'h8000_0000; dwe = 4'hF; dwdata = 32'hCAFE_F00D;
        #1 check("unmapped_read", drdata, 32'h0);
        check("bus_err_before", {31'b0, bus_err}, 32'h0);
        tick();
        dwe = 4'h0;
        #1 check("bus_err_after", {31'b0, bus_err}, 32'h1);
        daddr = 32'h0;
        #1 check("unmapped_write_dropped", drdata, c0);

        // Reset with five bytes queued.
        for (int b = 0; b < 6; b++) push_byte(8'(8'h60 + b));
        daddr = A_CYCLE; tx_ready = 1'b1;
        tick();
        tx_ready = 1'b0;
        check_fifo("pre_reset");
        check("pre_reset_head", {24'b0, tx_data}, 32'h61);
        #2 reset_n = 1'b0;
        txq.delete();
        ovf_m = 1'b0;
        bus_err_m = 1'b0;
        #1 check("reset_tx_valid", {31'b0, tx_valid}, 32'h0);
        check("reset_tx_data", {24'b0, tx_data}, 32'h0);
        check("reset_cycle", drdata, 32'h0);
        check("reset_bus_err", {31'b0, bus_err}, 32'h0);
        daddr = 32'h10; dwe = 4'hF; dwdata = 32'hDEAD_BEEF;
        tick();
        tick();
        check("ram_read_in_reset", drdata, 32'h11BB_33DD);
        dwe = 4'h0; daddr = A_CYCLE;
        #1 check("cycle_held_in_reset", drdata, 32'h0);
        reset_n = 1'b1;
        daddr = A_STATUS;
        #1 check("post_reset_status", drdata, 32'h0000_0001);
        check_fifo("post_reset");
        daddr = 32'h10;
        #1 check("post_reset_ram", drdata, 32'h11BB_33DD);
        expect_read("post_reset_ram_model");

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/dmem_responder.md
Name: dmem_responder

Overview:
- Data-memory responder for the single-cycle CPU's data port (daddr/dwdata/dwe in, drdata out).
- Provides a word-organised RAM with byte-lane writes and a small MMIO window:
  - a console transmit FIFO drained through a valid/ready handshake;
  - a status register;
  - a free-running cycle counter.
- Reads are combinational, as the single-cycle datapath requires. Writes commit on the rising clock edge.

Parameters:
- DEPTH_WORDS, 1024: RAM size in 32-bit words; power of two.
- FIFO_DEPTH, 8: transmit FIFO entries; power of two, ≥2.
- MMIO_BASE, 32'hFFFF_0000: base of the MMIO window, which is decoded on daddr[31:16].

Ports:
- clk  in  1  system clock, rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- daddr  in  32  byte address from the CPU.
- dwdata  in  32  write data, lane-aligned by the CPU.
- dwe  in  4  byte-lane write enables; bit i qualifies dwdata[8i+7:8i].
- drdata  out  32  read data, combinational from daddr and current state.
- tx_data  out  8  head of the transmit FIFO.
- tx_valid  out  1  FIFO non-empty.
- tx_ready  in  1  consumer accepts tx_data this cycle.
- bus_err  out  1  sticky flag: an unmapped access occurred.

Behaviour:
- Address decode:
  - MMIO when daddr[31:16]==MMIO_BASE[31:16].
  - RAM when daddr[31:2] < DEPTH_WORDS.
  - Otherwise unmapped.
  - daddr[1:0] is ignored everywhere; the CPU performs lane selection and extension.
- RAM:
  - drdata = mem[daddr[log2(DEPTH_WORDS)+1:2]] combinationally.
  - At posedge, each lane with dwe[i]=1 is written; other lanes are unchanged.
  - Contents are not reset.
  - A read and a write to the same word in one cycle returns the old data.
- MMIO offset 0x0, TXDATA:
  - A write with dwe[0]=1 pushes dwdata[7:0].
  - Reads return 0.
- MMIO offset 0x4, STATUS:
  - Read layout: [0] empty, [1] full, [2] overflow, [15:8] occupancy count (zero-extended), all other bits 0.
  - A write with dwe[0]=1 and dwdata[2]=1 clears overflow.
  - If the same edge also sets overflow, the set wins.
- MMIO offset 0x8, CYCLE:
  - 32-bit counter incremented every clock; wraps from FFFF_FFFF to 0.
  - Writes are ignored.
- Other MMIO offsets read 0 and ignore writes. They do not set bus_err.
- Unmapped access:
  - Reads return 0; writes are dropped.
  - bus_err sets on the next edge when any access occurs. An access is any dwe≠0 write, or any cycle with a non-RAM, non-MMIO daddr.
  - bus_err is cleared only by reset.
  - Consequence: the CPU always drives daddr, so idle cycles with an unmapped daddr also set the flag. This is accepted; software keeps daddr mapped.
- FIFO:
  - tx_valid = !empty; tx_data = head entry. tx_data is 0 when empty.
  - Pop occurs at posedge when tx_valid && tx_ready.
  - Push when not full: accepted.
  - Push when full with no pop in the same cycle: data dropped, overflow set.
  - Push when full with a pop in the same cycle: both occur, count unchanged, no overflow.
  - Push when empty: tx_valid rises after the edge. There is no bypass, so latency is 1 cycle.
  - Pointers wrap modulo FIFO_DEPTH. Count ranges 0..FIFO_DEPTH.
- Reset (asynchronous assert, sampled deassert):
  - FIFO pointers, count and overflow are cleared; CYCLE is cleared; bus_err is cleared.
  - tx_valid=0 and tx_data=0 immediately on assertion.
  - Mid-drain reset discards all queued bytes.
  - While reset_n=0, all writes are ignored and CYCLE holds at 0.
  - drdata is still driven for RAM reads during reset.

Decomposition:
- Shared package dmem_pkg holds:
  - MMIO offsets OFF_TXDATA/OFF_STATUS/OFF_CYCLE;
  - STATUS bit positions;
  - the MMIO_BASE default.
- One sub-module, tx_fifo, is parameterised by width and depth. It has push/pop/full/empty/count ports and the same clk/reset_n.
- RAM, decode, CYCLE and bus_err live in the top level.

Test Plan:
- Write dwe=4'b0101, dwdata=32'hAABBCCDD to daddr 0x10, after prior content 0x11223344 -> read of 0x10 returns 0x11BB33DD.
- With tx_ready=0, push bytes 0x41..0x48 to TXDATA -> STATUS=0x0802 (full, count 8). A 9th push of 0x49 -> overflow set, STATUS=0x0806. Then raise tx_ready -> tx_data sequence is 0x41..0x48, with one byte per cycle.
- Hold the FIFO full, push 0x5A while tx_ready=1 -> head advances, count stays 8, overflow stays 0. 0x5A is drained last.
- Write STATUS with dwdata=0x4 -> overflow clears. Read CYCLE twice, N cycles apart -> difference equals N, including across a forced FFFF_FFFF->0 wrap.
- Write to address 0x8000_0000 -> bus_err=1 after the edge, and a read of that address returns 0.
- Assert reset_n=0 mid-drain with 5 bytes queued -> tx_valid=0 immediately, CYCLE=0, bus_err=0. After release, STATUS reads 0x0001 and previously written RAM contents are intact.
